// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: phase encodings, the top-level
// state enum and the MIPS opcode/funct fields it decodes.
package phase_seq_pkg;

  localparam logic [4:0] P0 = 5'b00001;  // fetch
  localparam logic [4:0] P1 = 5'b00010;  // decode
  localparam logic [4:0] P2 = 5'b00100;  // execute
  localparam logic [4:0] P3 = 5'b01000;  // load/store
  localparam logic [4:0] P4 = 5'b10000;  // writeback

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [2:0] LOAD_PFX   = 3'b100;
  localparam logic [2:0] STORE_PFX  = 3'b101;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op[5:3] == LOAD_PFX) || (op[5:3] == STORE_PFX);
  endfunction

endpackage

// File: rtl/phase_seq_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + ONE;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/phase_seq.sv
// Multi-cycle MIPS phase sequencer: one-hot P0..P4 with memory handshake stalls,
// timeout fault, BREAK halt and saturating activity counters.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  input  logic             mem_ack,
  output logic [4:0]       p,
  output logic             mem_req,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t              state_reg, state_next;
  logic [4:0]          p_reg, p_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic                halted_reg, halted_next;
  logic                timeout_reg, timeout_next;
  logic                req_c;
  logic                retire;
  logic                is_break;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      p_reg       <= '0;
      wait_reg    <= '0;
      halted_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      p_reg       <= p_next;
      wait_reg    <= wait_next;
      halted_reg  <= halted_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    p_next       = p_reg;
    wait_next    = wait_reg;
    halted_next  = halted_reg;
    timeout_next = timeout_reg;
    req_c        = 1'b0;
    retire       = 1'b0;
    is_break     = (op == OP_SPECIAL) && (irfunc == FN_BREAK);

    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next = RUN;
          p_next     = P0;
        end
      end

      RUN: begin
        req_c = (p_reg == P0) || ((p_reg == P3) && is_mem_op(op));
        if (req_c) begin
          // An ack on the last allowed cycle still completes the access.
          if (mem_ack) begin
            wait_next = '0;
            p_next    = (p_reg == P0) ? P1 : P4;
          end else if (wait_reg == WAIT_LAST) begin
            state_next   = FAULT;
            p_next       = '0;
            timeout_next = 1'b1;
          end else begin
            wait_next = wait_reg + WAIT_ONE;
          end
        end else begin
          case (p_reg)
            P1: begin
              if (is_break) begin
                state_next  = HALT;
                p_next      = '0;
                halted_next = 1'b1;
                retire      = 1'b1;
              end else begin
                p_next = P2;
              end
            end
            P2: p_next = P3;
            P3: p_next = P4;
            P4: begin
              retire = 1'b1;
              if (run) begin
                p_next = P0;
              end else begin
                state_next = IDLE;
                p_next     = '0;
              end
            end
            default: ;
          endcase
        end
      end

      default: ;  // HALT and FAULT wait for reset
    endcase
  end

  assign p       = p_reg;
  assign mem_req = req_c;
  assign halted  = halted_reg;
  assign timeout = timeout_reg;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_reg == RUN),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .q     (instr_cnt)
  );

endmodule

// File: tb/tb_phase_seq.sv
// Self-checking bench for phase_seq: directed vector tables, hand-written
// corner sequences and a randomized run against an instruction-level model.
module tb_phase_seq;

  localparam int CNT_W    = 5;   // small so saturation is reachable
  localparam int MAX_WAIT = 15;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [5:0] ADD_OP = 6'b000000;
  localparam logic [5:0] ADD_FN = 6'b100000;
  localparam logic [5:0] BRK_FN = 6'b001101;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [5:0]       op;
  logic [5:0]       irfunc;
  logic             mem_ack;
  logic [4:0]       p;
  logic             mem_req;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_seq #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .op        (op),
    .irfunc    (irfunc),
    .mem_ack   (mem_ack),
    .p         (p),
    .mem_req   (mem_req),
    .halted    (halted),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  typedef struct {
    bit         rst;
    logic       run;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ack;
    logic [4:0] p;
    logic       req;
    bit         cc;
    int         cyc;
    int         ins;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    run     = 1'b0;
    op      = 6'd0;
    irfunc  = 6'd0;
    mem_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic add(input bit rst, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic a, input logic [4:0] ep, input logic er,
                     input bit cc, input int cyc, input int ins);
    vec_t v;
    v.rst = rst; v.run = r; v.op = o; v.fn = f; v.ack = a;
    v.p = ep; v.req = er; v.cc = cc; v.cyc = cyc; v.ins = ins;
    tbl.push_back(v);
  endtask

  // instruction-level reference model state
  int m_mode;  // 0 idle, 1 running, 2 halted, 3 faulted
  int m_ph;
  int m_wait;
  int m_cyc;
  int m_ins;

  initial begin
    // ---------------- vector tables ----------------
    // ADD with zero-wait memory
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b00000, 0, 1, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b00001, 1, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b00010, 0, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b00100, 0, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b01000, 0, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b10000, 0, 0, 0, 0);
    add(0, 1, ADD_OP, ADD_FN, 1, 5'b00001, 1, 1, 5, 1);
    // LW: 3 stalls in P0, 2 stalls in P3, run dropped in P4
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, LW_OP, 6'd0, 0, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, LW_OP, 6'd0, 0, 5'b00001, 1, 0, 0, 0);
    add(0, 1, LW_OP, 6'd0, 1, 5'b00001, 1, 0, 0, 0);
    add(0, 1, LW_OP, 6'd0, 0, 5'b00010, 0, 0, 0, 0);
    add(0, 1, LW_OP, 6'd0, 0, 5'b00100, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, LW_OP, 6'd0, 0, 5'b01000, 1, 0, 0, 0);
    add(0, 1, LW_OP, 6'd0, 1, 5'b01000, 1, 0, 0, 0);
    add(0, 0, LW_OP, 6'd0, 0, 5'b10000, 0, 0, 0, 0);
    add(0, 0, LW_OP, 6'd0, 0, 5'b00000, 0, 1, 10, 1);

    reset = 1'b1; run = 1'b0; op = 6'd0; irfunc = 6'd0; mem_ack = 1'b0;
    #1;
    chk("reset_p", {27'd0, p}, 32'd0);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        run = tbl[i].run; op = tbl[i].op; irfunc = tbl[i].fn; mem_ack = tbl[i].ack;
        #1;
        chk($sformatf("vec%0d_p", i), {27'd0, p}, {27'd0, tbl[i].p});
        chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
        if (tbl[i].cc) begin
          chk($sformatf("vec%0d_cycle_cnt", i), 32'(cycle_cnt), 32'(tbl[i].cyc));
          chk($sformatf("vec%0d_instr_cnt", i), 32'(instr_cnt), 32'(tbl[i].ins));
        end
        tick();
      end
    end

    // ---------------- timeout: ack never comes ----------------
    do_reset();
    run = 1'b1; op = ADD_OP; irfunc = ADD_FN; mem_ack = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("to_p0_cycle15", {27'd0, p}, 32'h1);
    chk("to_no_fault_yet", {31'd0, timeout}, 32'd0);
    tick();
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_p", {27'd0, p}, 32'd0);
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk("to_halted", {31'd0, halted}, 32'd0);
    chk("to_cycle_cnt", 32'(cycle_cnt), 32'd15);
    run = 1'b0; tick(); run = 1'b1; tick(); mem_ack = 1'b1; tick();
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    chk("to_sticky_p", {27'd0, p}, 32'd0);

    // ---------------- timeout boundary: ack on 15th cycle ----------------
    do_reset();
    run = 1'b1; op = ADD_OP; irfunc = ADD_FN; mem_ack = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    mem_ack = 1'b1;
    tick();
    chk("ack15_p", {27'd0, p}, 32'h2);
    chk("ack15_timeout", {31'd0, timeout}, 32'd0);

    // ---------------- BREAK ----------------
    do_reset();
    run = 1'b1; op = ADD_OP; irfunc = BRK_FN; mem_ack = 1'b1;
    tick(); tick(); tick();
    chk("brk_halted", {31'd0, halted}, 32'd1);
    chk("brk_p", {27'd0, p}, 32'd0);
    chk("brk_req", {31'd0, mem_req}, 32'd0);
    chk("brk_instr_cnt", 32'(instr_cnt), 32'd1);
    chk("brk_timeout", {31'd0, timeout}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick();
    end
    chk("brk_hold_p", {27'd0, p}, 32'd0);
    chk("brk_hold_halted", {31'd0, halted}, 32'd1);
    chk("brk_hold_instr", 32'(instr_cnt), 32'd1);
    chk("brk_hold_cycle", 32'(cycle_cnt), 32'd2);

    // ---------------- run dropped during P2 ----------------
    do_reset();
    run = 1'b1; op = ADD_OP; irfunc = ADD_FN; mem_ack = 1'b1;
    tick(); tick(); tick();
    chk("drop_p2", {27'd0, p}, 32'h4);
    run = 1'b0;
    tick();
    chk("drop_p3", {27'd0, p}, 32'h8);
    tick();
    chk("drop_p4", {27'd0, p}, 32'h10);
    tick();
    chk("drop_idle", {27'd0, p}, 32'd0);
    chk("drop_instr", 32'(instr_cnt), 32'd1);
    run = 1'b1;
    tick();
    chk("drop_rerun_p0", {27'd0, p}, 32'h1);

    // ---------------- async reset mid-P3 of SW ----------------
    do_reset();
    run = 1'b1; op = SW_OP; irfunc = 6'd0; mem_ack = 1'b1;
    tick(); tick(); tick();
    mem_ack = 1'b0;
    tick();
    chk("sw_p3", {27'd0, p}, 32'h8);
    chk("sw_p3_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_p", {27'd0, p}, 32'd0);
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_cycle", 32'(cycle_cnt), 32'd0);
    chk("arst_instr", 32'(instr_cnt), 32'd0);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("arst_idle", {27'd0, p}, 32'd0);

    // ---------------- randomized against reference model ----------------
    for (int ep = 0; ep < 30; ep++) begin
      int pct;
      int len;
      case (ep % 3)
        0: pct = 90;
        1: pct = 50;
        default: pct = 3;
      endcase
      len = $urandom_range(40, 80);
      do_reset();
      m_mode = 0; m_ph = 0; m_wait = 0; m_cyc = 0; m_ins = 0;
      for (int c = 0; c < len; c++) begin
        int k;
        bit m_req;
        bit brk;
        bit mem;
        logic [4:0] exp_p;
        run = ($urandom_range(0, 99) < 85);
        k = $urandom_range(0, 19);
        if (k < 8) begin
          op = ADD_OP; irfunc = 6'($urandom);
          if (irfunc == BRK_FN) irfunc = ADD_FN;
        end else if (k < 14) begin
          op = {($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101, 3'($urandom)};
          irfunc = 6'($urandom);
        end else if (k == 19) begin
          op = ADD_OP; irfunc = BRK_FN;
        end else begin
          op = {3'b001, 3'($urandom)}; irfunc = 6'($urandom);
        end
        mem_ack = ($urandom_range(0, 99) < pct);
        #1;
        brk   = (op == 6'd0) && (irfunc == BRK_FN);
        mem   = (op[5:3] == 3'b100) || (op[5:3] == 3'b101);
        m_req = (m_mode == 1) && ((m_ph == 0) || ((m_ph == 3) && mem));
        exp_p = (m_mode == 1) ? 5'(1 << m_ph) : 5'd0;
        chk("rnd_p", {27'd0, p}, {27'd0, exp_p});
        chk("rnd_req", {31'd0, mem_req}, {31'd0, m_req});
        chk("rnd_halted", {31'd0, halted}, {31'd0, m_mode == 2});
        chk("rnd_timeout", {31'd0, timeout}, {31'd0, m_mode == 3});
        chk("rnd_cycle_cnt", 32'(cycle_cnt), 32'((m_cyc > CNT_MAX) ? CNT_MAX : m_cyc));
        chk("rnd_instr_cnt", 32'(instr_cnt), 32'((m_ins > CNT_MAX) ? CNT_MAX : m_ins));
        case (m_mode)
          0: if (run) begin m_mode = 1; m_ph = 0; end
          1: begin
            m_cyc++;
            if (m_req) begin
              if (mem_ack) begin m_wait = 0; m_ph++; end
              else if (m_wait == MAX_WAIT - 1) m_mode = 3;
              else m_wait++;
            end else if (m_ph == 1 && brk) begin
              m_mode = 2; m_ins++;
            end else if (m_ph == 4) begin
              m_ins++;
              if (run) m_ph = 0;
              else m_mode = 0;
            end else begin
              m_ph++;
            end
          end
          default: ;
        endcase
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
Name: phase_seq

Overview:
- Registered phase sequencer for the multi-cycle MIPS core.
- Generates the one-hot phase vector p[4:0] (P0 fetch .. P4 writeback) consumed by the combinational control unit.
- Stalls P0 fetch and P3 load/store on a memory req/ack handshake, faults on memory timeout, and halts on BREAK.
- Keeps saturating cycle and retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- MAX_WAIT, 15, consecutive unacknowledged mem_req cycles that trigger FAULT (range 1..255).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- run  input  1  start/continue execution; sampled at instruction boundaries
- op  input  6  current IR opcode field
- irfunc  input  6  current IR funct field
- mem_ack  input  1  memory completes the current access this cycle
- p  output  5  one-hot phase, registered; 00000 when not running
- mem_req  output  1  memory access request (combinational from state and op)
- halted  output  1  sticky; BREAK retired
- timeout  output  1  sticky; memory handshake timeout
- cycle_cnt  output  CNT_W  active cycles, saturating
- instr_cnt  output  CNT_W  retired instructions, saturating

Behaviour:
- States: IDLE, RUN, HALT, FAULT. In RUN, the phase register holds one of P0..P4.
- Reset values:
  - state=IDLE, p=00000, mem_req=0, halted=0, timeout=0.
  - cycle_cnt=0, instr_cnt=0, wait counter=0.
  - Reset asserted mid-instruction aborts it in the same instant; no partial retire is counted.
- IDLE: p=00000. If run=1 at an edge, the next state is RUN with p=00001 (P0).
- P0:
  - mem_req=1.
  - mem_ack=1 at an edge: advance to P1 and clear the wait counter.
  - Otherwise: stay in P0 and increment the wait counter.
- P1:
  - If op=000000 and irfunc=001101 (BREAK): next state is HALT, instr_cnt increments, p=00000.
  - Otherwise: advance to P2.
- P2: advance to P3 unconditionally.
- P3:
  - Memory op (op[5:3]=100 for loads or 101 for stores): mem_req=1 and same stall rule as P0.
  - Otherwise: mem_req=0 and advance to P4 next cycle.
- P4:
  - instr_cnt increments.
  - If run=1: next phase is P0.
  - If run=0: next state is IDLE. A deasserted run never aborts an in-flight instruction.
- Timeout:
  - The wait counter (width ceil(log2(MAX_WAIT+1))) counts consecutive cycles with mem_req=1 and mem_ack=0.
  - At an edge where the counter equals MAX_WAIT-1 and mem_ack=0: next state is FAULT, timeout=1, p=00000, mem_req=0.
  - If mem_ack=1 on that same edge, ack wins and there is no fault.
- mem_req is 0 in IDLE, HALT and FAULT, and during P1, P2, P4.
- HALT and FAULT are terminal until reset; run is ignored in both. halted and timeout are never both 1.
- cycle_cnt increments on every edge where state=RUN, including stall cycles. It holds at all-ones on saturation. instr_cnt saturates the same way.
- Latency:
  - Zero-wait instruction: 5 cycles P0..P4.
  - Each stall cycle adds 1.
  - Back-to-back instructions have no bubble (P4 to P0 directly).
- p changes only on clock edges. At most one bit of p is set.

Decomposition:
- Shared package holds:
  - Phase one-hot constants P0..P4.
  - State enum (IDLE, RUN, HALT, FAULT).
  - Opcode/funct constants: OP_SPECIAL=000000, FN_BREAK=001101, load prefix 100, store prefix 101.
  - The is_mem_op(op) function.
- Sub-module sat_counter (parameter W; ports clk, reset, inc, q) is instantiated twice for cycle_cnt and instr_cnt.

Test Plan:
- Reset, then run=1 with ADD (op=000000, irfunc=100000) and mem_ack tied to 1 → p sequence 00001,00010,00100,01000,10000,00001; mem_req=1 only in P0; instr_cnt=1 after the first P4; cycle_cnt=5.
- LW (op=100011), mem_ack low for 3 cycles in P0 and 2 in P3 → P0 held 4 cycles, P3 held 3 cycles; instr_cnt=1; cycle_cnt=10 at retire.
- mem_ack never asserted in P0, MAX_WAIT=15 → after 15 P0 cycles timeout=1, p=00000, mem_req=0; repeat with mem_ack=1 on the 15th cycle → no fault, p=00010.
- BREAK (op=000000, irfunc=001101) → after P1, halted=1, p=00000, instr_cnt increments by 1; subsequent run toggles leave state unchanged.
- run dropped during P2 → P3 and P4 complete, then IDLE with p=00000; run re-raised → P0 on the next edge.
- reset asserted asynchronously mid-P3 of SW (op=101011) → outputs clear before the next edge; counters=0; IDLE.
